// File: rtl/act_skew_feeder_if.sv
// Activation vector handshake between the upstream source and the skew feeder.
// valid/ready: a vector transfers on a rising CLK edge where in_valid and in_ready are both
// high; the source holds in_valid and in_data stable until that edge, in_ready may drop freely.
interface act_skew_feeder_if #(
  parameter int NUM_ROWS = 16,
  parameter int DATA_W   = 8
);
  logic                       in_valid;
  logic                       in_ready;
  logic [NUM_ROWS*DATA_W-1:0] in_data;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/act_skew_feeder.sv
// Left-edge activation feeder: accepts whole vectors, skews lane i by i cycles into the
// PE array, drains the diagonal with zeros and pulses done as the last datum leaves lane N-1.
module act_skew_feeder #(
  parameter int NUM_ROWS = 16,
  parameter int DATA_W   = 8,
  parameter int CNT_W    = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       EN,
  input  logic                       start,
  input  logic [CNT_W-1:0]           vec_count,
  act_skew_feeder_if.slave           feed,
  output logic [NUM_ROWS*DATA_W-1:0] active_left,
  output logic [NUM_ROWS-1:0]        lane_valid,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int DCW = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FEED  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                     state;
  state_t                     state_nx;
  logic [CNT_W-1:0]           remaining;
  logic [DCW-1:0]             drain_cnt;
  logic                       zero_pend;
  logic                       accept;
  logic                       last_accept;
  logic                       start_tile;
  logic                       start_zero;
  logic                       drain_end;
  logic [NUM_ROWS*DATA_W-1:0] inject_data;

  assign feed.in_ready = EN && (state == S_FEED);
  assign busy          = (state != S_IDLE);
  assign state_dbg     = state;

  always_comb begin
    accept      = EN && (state == S_FEED) && feed.in_valid;
    last_accept = accept && (remaining == CNT_W'(1));
    start_tile  = EN && (state == S_IDLE) && start && (vec_count != '0);
    start_zero  = EN && (state == S_IDLE) && start && (vec_count == '0);
    drain_end   = (state == S_DRAIN) && (drain_cnt == '0);
    inject_data = accept ? feed.in_data : '0;
  end

  // done is gated by EN so a frozen drain cannot stretch the pulse over several cycles.
  assign done = EN && (drain_end || zero_pend);

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (EN) begin
      case (state)
        S_IDLE:  if (start_tile)  state_nx = S_FEED;
        S_FEED:  if (last_accept) state_nx = S_DRAIN;
        S_DRAIN: if (drain_end)   state_nx = S_IDLE;
        default: state_nx = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      remaining <= '0;
      drain_cnt <= '0;
      zero_pend <= 1'b0;
    end else if (EN) begin
      zero_pend <= start_zero;
      if (start_tile)
        remaining <= vec_count;
      else if (accept)
        remaining <= remaining - CNT_W'(1);
      // The drain counts the lanes still holding the last vector after it enters lane 0.
      if (last_accept)
        drain_cnt <= DCW'(NUM_ROWS - 1);
      else if ((state == S_DRAIN) && (drain_cnt != '0))
        drain_cnt <= drain_cnt - DCW'(1);
    end
  end

  for (genvar i = 0; i < NUM_ROWS; i++) begin : g_lane
    logic [DATA_W-1:0] sd [0:i];
    logic [i:0]        sv;

    always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
        for (int j = 0; j <= i; j++) sd[j] <= '0;
        sv <= '0;
      end else if (EN) begin
        sd[0] <= inject_data[i*DATA_W +: DATA_W];
        sv[0] <= accept;
        for (int j = 1; j <= i; j++) begin
          sd[j] <= sd[j-1];
          sv[j] <= sv[j-1];
        end
      end
    end

    assign active_left[i*DATA_W +: DATA_W] = sd[i];
    assign lane_valid[i]                   = sv[i];
  end

endmodule

// File: tb/tb_act_skew_feeder.sv
// Randomized bench for act_skew_feeder: a timeline model predicts per-lane arrivals and done,
// a negedge monitor pops those predictions and compares every cycle.
module tb_act_skew_feeder;
  localparam int NR  = 16;
  localparam int DW  = 8;
  localparam int CW  = 16;
  localparam int BUS = NR * DW;

  logic           CLK = 1'b0;
  logic           RESET = 1'b1;
  logic           EN = 1'b0;
  logic           start = 1'b0;
  logic [CW-1:0]  vec_count = '0;
  logic [BUS-1:0] active_left;
  logic [NR-1:0]  lane_valid;
  logic           busy;
  logic           done;
  logic [1:0]     state_dbg;

  act_skew_feeder_if #(.NUM_ROWS(NR), .DATA_W(DW)) feed ();

  act_skew_feeder #(.NUM_ROWS(NR), .DATA_W(DW), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .start(start), .vec_count(vec_count),
    .feed(feed), .active_left(active_left), .lane_valid(lane_valid),
    .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  always #5 CLK = ~CLK;

  // Model: ecyc counts enabled edges; a vector accepted at edge E shows on lane i after edge E+i.
  int              n_vec = 0;
  int              n_miss = 0;
  int              ecyc = 0;
  int              m_rem = 0;
  int              done_due = -1;
  bit              feeding = 0;
  bit              draining = 0;
  bit              zero_case = 0;
  bit              edge_seen = 0;
  logic [DW+31:0]  exp_q [NR][$];
  logic [BUS-1:0]  exp_al = '0;
  logic [NR-1:0]   exp_lv = '0;

  task automatic check(input string name, input logic [BUS-1:0] act, input logic [BUS-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) begin
    bit pre_feed;
    bit pre_drain;
    if (!RESET && EN) begin
      pre_feed  = feeding;
      pre_drain = draining;
      if (pre_drain && ecyc == done_due) begin
        draining  = 0;
        zero_case = 0;
      end
      ecyc++;
      if (pre_feed && feed.in_valid) begin
        for (int i = 0; i < NR; i++)
          exp_q[i].push_back({32'(ecyc + i), feed.in_data[i*DW +: DW]});
        m_rem--;
        if (m_rem == 0) begin
          feeding  = 0;
          draining = 1;
          done_due = ecyc + NR - 1;
        end
      end
      if (!pre_feed && !pre_drain && start) begin
        if (vec_count != '0) begin
          feeding = 1;
          m_rem   = int'(vec_count);
        end else begin
          draining  = 1;
          zero_case = 1;
          done_due  = ecyc;
        end
      end
      edge_seen = 1;
    end
  end

  always @(negedge CLK) begin
    logic [DW+31:0] e;
    if (edge_seen) begin
      edge_seen = 0;
      exp_al    = '0;
      exp_lv    = '0;
      for (int i = 0; i < NR; i++) begin
        if (exp_q[i].size() > 0) begin
          e = exp_q[i][0];
          if (int'(e[DW+31:DW]) == ecyc) begin
            void'(exp_q[i].pop_front());
            exp_al[i*DW +: DW] = e[DW-1:0];
            exp_lv[i]          = 1'b1;
          end
        end
      end
    end
    check("active_left", active_left, exp_al);
    check("lane_valid", BUS'(lane_valid), BUS'(exp_lv));
    check("done", BUS'(done), BUS'(EN && draining && ecyc == done_due));
    check("busy", BUS'(busy), BUS'(feeding || (draining && !zero_case)));
    check("in_ready", BUS'(feed.in_ready), BUS'(EN && feeding));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) exp_q[i].delete();
    feeding   = 0;
    draining  = 0;
    zero_case = 0;
    m_rem     = 0;
    edge_seen = 0;
    exp_al    = '0;
    exp_lv    = '0;
  endtask

  // Asserted mid-cycle so the asynchronous clear is visible before the next edge.
  task automatic mid_reset();
    #3;
    RESET = 1'b1;
    model_clear();
    #1;
    check("rst_active_left", active_left, '0);
    check("rst_lane_valid", BUS'(lane_valid), '0);
    check("rst_done", BUS'(done), '0);
    check("rst_busy", BUS'(busy), '0);
    check("rst_in_ready", BUS'(feed.in_ready), '0);
    step();
    step();
    RESET = 1'b0;
  endtask

  function automatic logic [BUS-1:0] make_vec(input int pat, input int k);
    logic [BUS-1:0] v;
    for (int i = 0; i < NR; i++) begin
      if (pat == 1)      v[i*DW +: DW] = DW'(i + 1);
      else if (pat == 2) v[i*DW +: DW] = DW'(16 * k + i);
      else               v[i*DW +: DW] = DW'($urandom);
    end
    return v;
  endfunction

  task automatic wait_idle(input int budget, input bit start_mid, input bit reset_mid);
    int g = 0;
    while ((feeding || draining) && g < budget) begin
      if (start_mid && g == 3) begin
        start     = 1'b1;
        vec_count = CW'(5);
      end else begin
        start = 1'b0;
      end
      if (reset_mid && g == 6) mid_reset();
      else step();
      g++;
    end
    start = 1'b0;
    n_vec++;
    if (feeding || draining) begin
      n_miss++;
      $display("FAIL idle_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic send_tile(input int n, input int pat, input int bub_pct, input int en_pct,
                           input int gap_at, input int gap_len, input bit gap_en,
                           input bit start_mid, input bit reset_mid);
    int             k = 0;
    int             g = 0;
    int             gc = 0;
    bit             acc;
    logic [BUS-1:0] v;
    EN            = 1'b1;
    feed.in_valid = 1'b0;
    start         = 1'b1;
    vec_count     = CW'(n);
    step();
    start     = 1'b0;
    vec_count = CW'($urandom);
    v = make_vec(pat, 0);
    while (k < n && g < 4000) begin
      feed.in_data = v;
      if (k == gap_at && gc < gap_len) begin
        gc++;
        EN            = !gap_en;
        feed.in_valid = gap_en;
        step();
      end else begin
        EN            = ($urandom_range(99) >= en_pct);
        feed.in_valid = ($urandom_range(99) >= bub_pct);
        @(negedge CLK);
        acc = feed.in_valid && feed.in_ready;
        step();
        if (acc) begin
          k++;
          v = make_vec(pat, k);
        end
      end
      g++;
    end
    feed.in_valid = 1'b0;
    EN            = 1'b1;
    n_vec++;
    if (k < n) begin
      n_miss++;
      $display("FAIL feed_timeout: accepted %0d vectors, required %0d", k, n);
    end
    wait_idle(200, start_mid, reset_mid);
  endtask

  task automatic zero_tile();
    EN        = 1'b1;
    start     = 1'b1;
    vec_count = '0;
    step();
    start     = 1'b0;
    vec_count = CW'($urandom);
    repeat (4) step();
  endtask

  initial begin
    feed.in_valid = 1'b0;
    feed.in_data  = '0;
    EN            = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    check("init_active_left", active_left, '0);
    check("init_lane_valid", BUS'(lane_valid), '0);
    check("init_busy", BUS'(busy), '0);
    RESET = 1'b0;
    repeat (10) step();

    send_tile(1, 1, 0, 0, -1, 0, 0, 0, 0);
    send_tile(4, 2, 0, 0, -1, 0, 0, 0, 0);
    send_tile(4, 0, 0, 0, 1, 2, 0, 0, 0);
    send_tile(5, 0, 0, 0, 2, 3, 1, 0, 0);
    zero_tile();
    send_tile(3, 0, 0, 0, -1, 0, 0, 1, 0);
    send_tile(2, 0, 0, 0, -1, 0, 0, 0, 1);
    send_tile(1, 1, 0, 0, -1, 0, 0, 0, 0);

    for (int t = 0; t < 30; t++) begin
      if ($urandom_range(9) == 0) zero_tile();
      send_tile($urandom_range(1, 12), 0, $urandom_range(0, 40), $urandom_range(0, 25),
                -1, 0, 0, ($urandom_range(3) == 0), 0);
      repeat ($urandom_range(0, 2)) step();
    end
    repeat (3) step();

    for (int i = 0; i < NR; i++)
      check("leftover_lane", BUS'(exp_q[i].size()), '0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #2000000;
    n_miss++;
    $display("FAIL watchdog: simulation did not finish, required finish before 2ms");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $fatal(1, "watchdog expired");
  end

endmodule
